// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with add/sub/logic/shift, shift-add multiply and an accumulator.
// Latency: non-MUL ops produce a result the cycle after acceptance; MUL after WIDTH+1 cycles.
// Backpressure: the result is held while out_valid && !out_ready; in_ready drops until it is consumed.
// Ports: clk/rst_n; request in_valid/in_ready/op/a/b/cin/acc_clr;
//        response out_valid/out_ready/result/carry/ovf/zero/neg.
module alu_seq #(
  parameter int WIDTH    = 5,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ACC = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 accept;
  logic [WIDTH-1:0]     acc_base;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_dif;
  logic [WIDTH:0]       acc_sum;
  logic [2*WIDTH-1:0]   prod_nxt;
  logic [WIDTH-1:0]     ones;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_OUT);
  assign result    = result_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = (result_q == '0);
  assign neg       = result_q[MSB];

  assign ones      = '1;
  // A clear in the same cycle as an accepted ACC takes effect before the add.
  assign acc_base  = acc_clr ? '0 : acc_q;
  assign add_sum   = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
  // Bit WIDTH of the (WIDTH+1)-bit difference is the borrow out.
  assign sub_dif   = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
  assign acc_sum   = {1'b0, acc_base} + {1'b0, a};
  assign prod_nxt  = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_clr ? '0 : acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE, S_OUT: begin
        if (state_q == S_OUT && out_ready) state_d = S_IDLE;
        if (accept) begin
          state_d = S_OUT;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          unique case (op)
            OP_ADD: begin
              carry_d  = add_sum[WIDTH];
              ovf_d    = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
              result_d = (SATURATE && add_sum[WIDTH]) ? ones : add_sum[WIDTH-1:0];
            end
            OP_SUB: begin
              carry_d  = sub_dif[WIDTH];
              ovf_d    = (a[MSB] != b[MSB]) && (sub_dif[MSB] != a[MSB]);
              result_d = (SATURATE && sub_dif[WIDTH]) ? '0 : sub_dif[WIDTH-1:0];
            end
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_XOR: result_d = a ^ b;
            OP_SHL: begin
              result_d = {a[WIDTH-2:0], cin};
              carry_d  = a[MSB];
            end
            OP_MUL: begin
              state_d  = S_BUSY;
              prod_d   = '0;
              mcand_d  = {{WIDTH{1'b0}}, a};
              mplier_d = b;
              cnt_d    = '0;
            end
            OP_ACC: begin
              carry_d  = acc_sum[WIDTH];
              ovf_d    = (acc_base[MSB] == a[MSB]) && (acc_sum[MSB] != a[MSB]);
              result_d = (SATURATE && acc_sum[WIDTH]) ? ones : acc_sum[WIDTH-1:0];
              acc_d    = result_d;
            end
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        // One multiplier bit per cycle; the last step publishes the product directly.
        prod_d   = prod_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = S_OUT;
          result_d = prod_nxt[WIDTH-1:0];
          carry_d  = |prod_nxt[2*WIDTH-1:WIDTH];
          ovf_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq, one wrapping and one saturating instance on shared inputs.
// Latency: checks 1-cycle non-MUL and WIDTH+1-cycle MUL result timing.
// Backpressure: exercises held results, stalled requests and reset during a multiply.
module tb_alu_seq;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         acc_clr = 1'b0;
  logic         out_ready = 1'b0;

  logic         r0_in_ready, r0_out_valid, r0_carry, r0_ovf, r0_zero, r0_neg;
  logic [W-1:0] r0_result;
  logic         r1_in_ready, r1_out_valid, r1_carry, r1_ovf, r1_zero, r1_neg;
  logic [W-1:0] r1_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0_in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .acc_clr(acc_clr),
    .out_valid(r0_out_valid), .out_ready(out_ready), .result(r0_result),
    .carry(r0_carry), .ovf(r0_ovf), .zero(r0_zero), .neg(r0_neg)
  );

  alu_seq #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1_in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .acc_clr(acc_clr),
    .out_valid(r1_out_valid), .out_ready(out_ready), .result(r1_result),
    .carry(r1_carry), .ovf(r1_ovf), .zero(r1_zero), .neg(r1_neg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         clr;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic [W-1:0] sres;
    logic         sc;
  } vec_t;

  vec_t vecs[20];

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"},   32'(r0_in_ready),  32'd1);
    chk({tag, "_vld"},   32'(r0_out_valid), 32'd0);
    chk({tag, "_res"},   32'(r0_result),    32'd0);
    chk({tag, "_carry"}, 32'(r0_carry),     32'd0);
    chk({tag, "_ovf"},   32'(r0_ovf),       32'd0);
    chk({tag, "_zero"},  32'(r0_zero),      32'd1);
    chk({tag, "_neg"},   32'(r0_neg),       32'd0);
    chk({tag, "_svld"},  32'(r1_out_valid), 32'd0);
    chk({tag, "_sres"},  32'(r1_result),    32'd0);
  endtask

  task automatic run_vec(input int i);
    int  lat;
    bit  rdy_seen;
    @(negedge clk);
    op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
    acc_clr = vecs[i].clr; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; acc_clr = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!r0_out_valid && lat < 20) begin
      if (r0_in_ready || r1_in_ready) rdy_seen = 1'b1;
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_latency", i), 32'(lat), (vecs[i].op == 3'b110) ? 32'(W + 1) : 32'd1);
    chk($sformatf("v%0d_busy_rdy", i), 32'(rdy_seen), 32'd0);
    chk($sformatf("v%0d_res", i),   32'(r0_result), 32'(vecs[i].res));
    chk($sformatf("v%0d_carry", i), 32'(r0_carry),  32'(vecs[i].c));
    chk($sformatf("v%0d_ovf", i),   32'(r0_ovf),    32'(vecs[i].v));
    chk($sformatf("v%0d_zero", i),  32'(r0_zero),   32'(vecs[i].res == '0));
    chk($sformatf("v%0d_neg", i),   32'(r0_neg),    32'(vecs[i].res[W-1]));
    chk($sformatf("v%0d_svld", i),  32'(r1_out_valid), 32'd1);
    chk($sformatf("v%0d_sres", i),  32'(r1_result), 32'(vecs[i].sres));
    chk($sformatf("v%0d_scarry", i), 32'(r1_carry), 32'(vecs[i].sc));
    chk($sformatf("v%0d_szero", i), 32'(r1_zero),   32'(vecs[i].sres == '0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d_drained", i), 32'(r0_out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit bad;
    bit leaked;
    //          op      a         b         cin  clr  res       c     v     sres      sc
    vecs[0]  = '{3'b000, 5'b10100, 5'b00000, 1'b1, 1'b0, 5'b10101, 1'b0, 1'b0, 5'b10101, 1'b0};
    vecs[1]  = '{3'b000, 5'b01111, 5'b00001, 1'b0, 1'b0, 5'b10000, 1'b0, 1'b1, 5'b10000, 1'b0};
    vecs[2]  = '{3'b000, 5'b11111, 5'b11111, 1'b1, 1'b0, 5'b11111, 1'b1, 1'b0, 5'b11111, 1'b1};
    vecs[3]  = '{3'b000, 5'b11111, 5'b00010, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b0, 5'b11111, 1'b1};
    vecs[4]  = '{3'b001, 5'b10101, 5'b01011, 1'b0, 1'b0, 5'b01010, 1'b0, 1'b1, 5'b01010, 1'b0};
    vecs[5]  = '{3'b001, 5'b00011, 5'b00101, 1'b0, 1'b0, 5'b11110, 1'b1, 1'b0, 5'b00000, 1'b1};
    vecs[6]  = '{3'b001, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b11111, 1'b1, 1'b0, 5'b00000, 1'b1};
    vecs[7]  = '{3'b010, 5'b11010, 5'b10110, 1'b1, 1'b0, 5'b10010, 1'b0, 1'b0, 5'b10010, 1'b0};
    vecs[8]  = '{3'b011, 5'b11010, 5'b00101, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 5'b11111, 1'b0};
    vecs[9]  = '{3'b100, 5'b11010, 5'b10110, 1'b0, 1'b0, 5'b01100, 1'b0, 1'b0, 5'b01100, 1'b0};
    vecs[10] = '{3'b101, 5'b10110, 5'b00000, 1'b1, 1'b0, 5'b01101, 1'b1, 1'b0, 5'b01101, 1'b1};
    vecs[11] = '{3'b101, 5'b01011, 5'b11111, 1'b0, 1'b0, 5'b10110, 1'b0, 1'b0, 5'b10110, 1'b0};
    vecs[12] = '{3'b110, 5'b00110, 5'b00111, 1'b0, 1'b0, 5'b01010, 1'b1, 1'b0, 5'b01010, 1'b1};
    vecs[13] = '{3'b110, 5'b00101, 5'b00011, 1'b1, 1'b0, 5'b01111, 1'b0, 1'b0, 5'b01111, 1'b0};
    vecs[14] = '{3'b110, 5'b11111, 5'b11111, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b0, 5'b00001, 1'b1};
    vecs[15] = '{3'b111, 5'b01010, 5'b00000, 1'b0, 1'b0, 5'b01010, 1'b0, 1'b0, 5'b01010, 1'b0};
    vecs[16] = '{3'b111, 5'b10100, 5'b00000, 1'b0, 1'b0, 5'b11110, 1'b0, 1'b0, 5'b11110, 1'b0};
    vecs[17] = '{3'b111, 5'b00101, 5'b00000, 1'b0, 1'b0, 5'b00011, 1'b1, 1'b0, 5'b11111, 1'b1};
    vecs[18] = '{3'b111, 5'b00111, 5'b00000, 1'b0, 1'b1, 5'b00111, 1'b0, 1'b0, 5'b00111, 1'b0};
    vecs[19] = '{3'b111, 5'b01001, 5'b00000, 1'b0, 1'b0, 5'b10000, 1'b0, 1'b1, 5'b10000, 1'b0};

    // Reset state, including an attempted request while reset is held.
    in_valid = 1'b1; op = 3'b000; a = 5'b00011; b = 5'b00001;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_vld", 32'(r0_out_valid), 32'd0);

    for (int i = 0; i < 20; i++) run_vec(i);

    // Backpressure: hold a result for 3 cycles while a SUB waits.
    @(negedge clk);
    op = 3'b000; a = 5'b00011; b = 5'b00100; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    op = 3'b001; a = 5'b01000; b = 5'b00011;
    chk("bp_first_vld", 32'(r0_out_valid), 32'd1);
    chk("bp_first_res", 32'(r0_result), 32'(5'b00111));
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (r0_result !== 5'b00111 || r0_in_ready !== 1'b0 || r0_out_valid !== 1'b1) bad = 1'b1;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_rise", 32'(r0_in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_vld", 32'(r0_out_valid), 32'd1);
    chk("bp_second_res", 32'(r0_result), 32'(5'b00101));
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_no_dup", 32'(r0_out_valid), 32'd0);

    // Reset in the third BUSY cycle of a multiply aborts it.
    @(negedge clk);
    op = 3'b110; a = 5'b00110; b = 5'b00111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mrst_busy_rdy", 32'(r0_in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mrst");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    leaked = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (r0_out_valid || r1_out_valid) leaked = 1'b1;
    end
    chk("mrst_no_result", 32'(leaked), 32'd0);
    out_ready = 1'b0;

    // Accumulator returns to zero on reset.
    @(negedge clk);
    op = 3'b111; a = 5'b00001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("acc_after_reset", 32'(r0_result), 32'(5'b00001));
    chk("acc_after_reset_c", 32'(r0_carry), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the 5-bit combinational adder/ALU used in the traffic-control datapath. It accepts one operation per valid/ready handshake, computes add, subtract, logic, shift, multi-cycle multiply and accumulate over a configurable word width, and returns a registered result with flags on an output handshake. It sits between the phase/timer control logic and any consumer needing arithmetic on counter values, such as timer reload sums or accumulated wait times.

## Interface
Parameters:
- WIDTH, 5, operand/result width in bits (≥2)
- SATURATE, 0, when 1, ADD/SUB/ACC clamp to unsigned limits instead of wrapping

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept an operation this cycle
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 ACC
- a  in  WIDTH  operand A, unsigned
- b  in  WIDTH  operand B, unsigned
- cin  in  1  carry-in for ADD, borrow-in for SUB, shift-in bit for SHL
- acc_clr  in  1  synchronous accumulator clear
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  operation result
- carry  out  1  carry, borrow or high-part flag, depending on op
- ovf  out  1  two's-complement overflow (ADD/SUB/ACC only, else 0)
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]

## Operation
- FSM has three states:
  - IDLE: no result pending, no operation in progress.
  - BUSY: multiply is iterating.
  - OUT: result is held for the consumer.
- in_ready = (state==IDLE) || (state==OUT && out_ready). Acceptance happens when in_valid && in_ready.
- On acceptance of a non-MUL op, the block computes and registers the result, then goes to OUT. MUL goes to BUSY.
- In OUT with out_ready=1 and no new acceptance, the block goes to IDLE. An acceptance in the same cycle goes directly to OUT or BUSY, giving back-to-back throughput.
- ADD: {carry,result} = a+b+cin. ovf = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
- SUB: result = a−b−cin mod 2^WIDTH. carry = 1 when a < b+cin (borrow). ovf uses signed subtract rule.
- AND/OR/XOR: bitwise. carry=0, ovf=0.
- SHL: result = {a[WIDTH-2:0],cin}. carry = a[WIDTH-1]. ovf=0.
- MUL: unsigned shift-add, one partial-product bit per cycle for WIDTH cycles.
  - result = low WIDTH bits of a*b.
  - carry = 1 if the high WIDTH bits are nonzero.
  - a and b are captured at acceptance; later input changes are ignored.
- ACC: {carry,acc} = acc+a, result = new acc, ovf uses signed add rule. acc updates only on acceptance.
- acc_clr:
  - Sets acc=0 at the clock edge, in any state.
  - If asserted in the same cycle an ACC op is accepted, the clear applies first, so result = a.
- SATURATE=1:
  - ADD/ACC overflow gives result (and acc) = 2^WIDTH−1.
  - SUB underflow gives result = 0.
  - carry still reports the unclamped carry/borrow.
  - ovf is unaffected by clamping.
- zero and neg are derived from the final registered result after any clamping.
- Inputs are ignored while in_ready=0. Ops are never dropped or duplicated.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, acc=0.
  - result, carry, ovf, neg, out_valid are 0. zero is 1, since result is 0.
  - in_ready reads 1; no acceptance occurs while rst_n is low.
- Non-MUL op accepted at edge t: out_valid=1 and flags are valid after edge t+1.
- MUL accepted at edge t: BUSY for WIDTH cycles, out_valid=1 after edge t+WIDTH+1. in_ready=0 throughout BUSY.
- Outputs hold stable while out_valid && !out_ready.
- Reset mid-MUL or mid-OUT aborts the operation. No result is emitted after reset is released.

## Test plan
- WIDTH=5, ADD a=10100 b=00000 cin=1 → one cycle later result=10101, carry=0, ovf=0, neg=1, zero=0.
- ADD a=01111 b=00001 cin=0 → 10000, ovf=1. ADD 11111+11111+1 → 11111, carry=1. With SATURATE=1, 11111+00010 → 11111, carry=1.
- SUB 10101−01011 cin=0 → 01010, carry=0. SUB 00011−00101 → 11110, carry=1. With SATURATE=1 → 00000, carry=1, zero=1.
- MUL 00110×00111 (42) → result=01010, carry=1. out_valid exactly WIDTH+1=6 cycles after acceptance, in_ready=0 during BUSY. A reset asserted at BUSY cycle 3 → all outputs at reset values, IDLE.
- ACC sequence a=01010, 10100, 00101 → results 01010, 11110, 00011 (carry=1 on the third). acc_clr together with ACC a=00111 → result 00111.
- Backpressure: hold out_ready=0 for 3 cycles after a result → result stable, in_ready=0, pending in_valid stalls. The stalled op is accepted in the cycle out_ready rises, and its result appears the next cycle.
